// File: rtl/common_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : common_types_pkg
// Brief    : Shared types for the RAM arbiter: word type, arbiter state
//            encoding and the latched RAM request record.
// Revision : 1.0 - initial release
// ============================================================================
package common_types_pkg;

  localparam int unsigned c_word_w = 32;

  typedef logic [c_word_w-1:0] word_t;

  // One state per RAM owner plus the idle/grant state
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IBUSY = 2'd1,
    ARB_DBUSY = 2'd2,
    ARB_OBUSY = 2'd3
  } arb_state_t;

  // Everything the RAM sees for one transaction, captured at grant time
  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t wdata;
  } ram_req_t;

  // Builds a request record from the granted requester's signals
  function automatic ram_req_t make_req(input logic  ren,
                                        input logic  wen,
                                        input word_t addr,
                                        input word_t wdata);
    ram_req_t r;
    r.ren   = ren;
    r.wen   = wen;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Shares the single-port system RAM between the CPU instruction
//            port, the CPU data port and the testbench override port. One RAM
//            transaction at a time; the RAM ends each one with ram_ready.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import common_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        clk,
  input  logic        nrst,
  // CPU instruction port
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // CPU data port
  input  logic        dren,
  input  logic        dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // Testbench dump / override port
  input  logic        override_ctrl,
  input  logic        ovr_ren,
  input  logic        ovr_wen,
  input  logic [31:0] ovr_addr,
  input  logic [31:0] ovr_wdata,
  output logic        ovr_wait,
  output logic [31:0] ovr_rdata,
  // RAM side
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);

  // Streak counter only needs to reach MAX_DSTREAK
  localparam int unsigned c_streak_w =
    (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_DSTREAK);

  arb_state_t            state_q, state_d;
  ram_req_t              req_q,   req_d;
  logic [c_streak_w-1:0] dstreak_q, dstreak_d;

  logic w_dreq;
  logic w_ovr_req;
  logic w_force_i;

  assign w_dreq    = dren | dwen;
  assign w_ovr_req = override_ctrl & (ovr_ren | ovr_wen);
  // The data port has had its fair share; the waiting fetch goes next
  assign w_force_i = iren & (dstreak_q == c_streak_max);

  // State, latched request and data streak registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ARB_IDLE;
      req_q     <= '0;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      dstreak_q <= dstreak_d;
    end
  end

  // Grant selection in IDLE; every busy state returns to IDLE on ram_ready
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      ARB_IDLE: begin
        if (w_ovr_req) begin
          state_d = ARB_OBUSY;
          req_d   = make_req(ovr_ren, ovr_wen, ovr_addr, ovr_wdata);
        end else if (!override_ctrl) begin
          // While the testbench owns the RAM the CPU is locked out
          if (w_dreq && !w_force_i) begin
            state_d = ARB_DBUSY;
            req_d   = make_req(dren, dwen, daddr, dstore);
          end else if (iren) begin
            state_d = ARB_IBUSY;
            req_d   = make_req(1'b1, 1'b0, iaddr, '0);
          end
        end
      end
      ARB_IBUSY, ARB_DBUSY, ARB_OBUSY: begin
        // Runs to completion even if the requester has gone away
        if (ram_ready) begin
          state_d = ARB_IDLE;
          req_d   = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        req_d   = '0;
      end
    endcase
  end

  // Count back-to-back data completions while a fetch is being held off
  always_comb begin
    dstreak_d = dstreak_q;
    if (!iren) begin
      dstreak_d = '0;
    end else if (ram_ready && state_q == ARB_IBUSY) begin
      dstreak_d = '0;
    end else if (ram_ready && state_q == ARB_DBUSY && dstreak_q != c_streak_max) begin
      dstreak_d = dstreak_q + 1'b1;
    end
  end

  // Handshake outputs: only the owner of a completing transaction sees it
  always_comb begin
    iwait     = 1'b1;
    dwait     = 1'b1;
    ovr_wait  = 1'b1;
    iload     = '0;
    dload     = '0;
    ovr_rdata = '0;
    if (ram_ready) begin
      case (state_q)
        ARB_IBUSY: begin
          iwait = 1'b0;
          iload = ram_rdata;
        end
        ARB_DBUSY: begin
          dwait = 1'b0;
          dload = ram_rdata;
        end
        ARB_OBUSY: begin
          ovr_wait  = 1'b0;
          ovr_rdata = ram_rdata;
        end
        default: begin
          iwait = 1'b1;
        end
      endcase
    end
  end

  // RAM strobes and bus come straight from the registered request
  assign ram_ren   = req_q.ren;
  assign ram_wen   = req_q.wen;
  assign ram_addr  = req_q.addr;
  assign ram_wdata = req_q.wdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed self-checking bench for ram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        iren = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dren = 1'b0;
  logic        dwen = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        override_ctrl = 1'b0;
  logic        ovr_ren = 1'b0;
  logic        ovr_wen = 1'b0;
  logic [31:0] ovr_addr = '0;
  logic [31:0] ovr_wdata = '0;
  logic        ovr_wait;
  logic [31:0] ovr_rdata;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  ram_arbiter #(.MAX_DSTREAK(4)) dut (
    .clk(clk), .nrst(nrst),
    .iren(iren), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .override_ctrl(override_ctrl), .ovr_ren(ovr_ren), .ovr_wen(ovr_wen),
    .ovr_addr(ovr_addr), .ovr_wdata(ovr_wdata), .ovr_wait(ovr_wait),
    .ovr_rdata(ovr_rdata),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    cyc(); cyc();
    total++; if ({ram_ren, ram_wen} !== 2'b00) begin bad++; $display("FAIL rst_strobes: got %b want 00", {ram_ren, ram_wen}); end
    total++; if ({ram_addr, ram_wdata} !== 64'h0) begin bad++; $display("FAIL rst_bus: got %h want 0", {ram_addr, ram_wdata}); end
    total++; if ({iwait, dwait, ovr_wait} !== 3'b111) begin bad++; $display("FAIL rst_waits: got %b want 111", {iwait, dwait, ovr_wait}); end
    total++; if ({iload, dload, ovr_rdata} !== 96'h0) begin bad++; $display("FAIL rst_loads: got %h want 0", {iload, dload, ovr_rdata}); end
    nrst = 1'b1;
    // ram_ready while idle must be ignored
    ram_ready = 1'b1; ram_rdata = 32'h1111_1111;
    cyc();
    total++; if ({ram_ren, ram_wen} !== 2'b00) begin bad++; $display("FAIL idle_ready_strobes: got %b want 00", {ram_ren, ram_wen}); end
    total++; if ({iwait, dwait, ovr_wait} !== 3'b111) begin bad++; $display("FAIL idle_ready_waits: got %b want 111", {iwait, dwait, ovr_wait}); end
    total++; if ({iload, dload, ovr_rdata} !== 96'h0) begin bad++; $display("FAIL idle_ready_loads: got %h want 0", {iload, dload, ovr_rdata}); end
    ram_ready = 1'b0;
    cyc();
  endtask

  task automatic test_ifetch();
    iren = 1'b1; iaddr = 32'h100;
    cyc();
    total++; if ({ram_ren, ram_wen} !== 2'b10) begin bad++; $display("FAIL if_strobes: got %b want 10", {ram_ren, ram_wen}); end
    total++; if (ram_addr !== 32'h100) begin bad++; $display("FAIL if_addr: got %h want 00000100", ram_addr); end
    total++; if (iwait !== 1'b1) begin bad++; $display("FAIL if_wait_pending: got %b want 1", iwait); end
    ram_ready = 1'b1; ram_rdata = 32'hDEAD_BEEF; #1;
    total++; if (iwait !== 1'b0) begin bad++; $display("FAIL if_wait_done: got %b want 0", iwait); end
    total++; if (iload !== 32'hDEAD_BEEF) begin bad++; $display("FAIL if_load: got %h want deadbeef", iload); end
    total++; if (dwait !== 1'b1) begin bad++; $display("FAIL if_dwait: got %b want 1", dwait); end
    cyc();
    ram_ready = 1'b0; iren = 1'b0; #1;
    total++; if (ram_ren !== 1'b0) begin bad++; $display("FAIL if_after_ren: got %b want 0", ram_ren); end
    total++; if (iwait !== 1'b1 || iload !== 32'h0) begin bad++; $display("FAIL if_after_wait: got %b/%h want 1/0", iwait, iload); end
    cyc();
  endtask

  task automatic test_priority();
    iren = 1'b1; iaddr = 32'h104; dwen = 1'b1; daddr = 32'h200; dstore = 32'h55;
    cyc();
    total++; if ({ram_ren, ram_wen} !== 2'b01) begin bad++; $display("FAIL pri_d_strobes: got %b want 01", {ram_ren, ram_wen}); end
    total++; if (ram_addr !== 32'h200 || ram_wdata !== 32'h55) begin bad++; $display("FAIL pri_d_bus: got %h/%h want 200/55", ram_addr, ram_wdata); end
    ram_ready = 1'b1; #1;
    total++; if ({iwait, dwait} !== 2'b10) begin bad++; $display("FAIL pri_d_waits: got %b want 10", {iwait, dwait}); end
    cyc();
    dwen = 1'b0; ram_ready = 1'b0;
    cyc();
    total++; if ({ram_ren, ram_wen} !== 2'b10) begin bad++; $display("FAIL pri_i_strobes: got %b want 10", {ram_ren, ram_wen}); end
    total++; if (ram_addr !== 32'h104 || ram_wdata !== 32'h0) begin bad++; $display("FAIL pri_i_bus: got %h/%h want 104/0", ram_addr, ram_wdata); end
    ram_ready = 1'b1; ram_rdata = 32'h0000_1234; #1;
    total++; if (iwait !== 1'b0 || iload !== 32'h1234) begin bad++; $display("FAIL pri_i_done: got %b/%h want 0/1234", iwait, iload); end
    cyc();
    iren = 1'b0; ram_ready = 1'b0;
    cyc();
  endtask

  task automatic test_dstreak();
    int g = 0;
    logic [31:0] exp_addr;
    iren = 1'b1; dren = 1'b1; iaddr = 32'h180; daddr = 32'h280;
    ram_rdata = 32'hA5; ram_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (ram_ren === 1'b1) begin
        exp_addr = (g == 4) ? 32'h180 : 32'h280;
        total++; if (ram_addr !== exp_addr) begin bad++; $display("FAIL streak_grant%0d: got %h want %h", g, ram_addr, exp_addr); end
        if (g == 0) begin
          total++; if (dwait !== 1'b0 || dload !== 32'hA5) begin bad++; $display("FAIL streak_dload: got %b/%h want 0/a5", dwait, dload); end
        end
        g++;
      end
    end
    total++; if (g !== 6) begin bad++; $display("FAIL streak_count: got %0d want 6", g); end
    iren = 1'b0; dren = 1'b0;
    cyc();
    ram_ready = 1'b0;
    cyc();
  endtask

  task automatic test_override();
    dren = 1'b1; daddr = 32'h2C0; ram_ready = 1'b0;
    cyc();
    override_ctrl = 1'b1; ovr_ren = 1'b1; ovr_addr = 32'h40; #1;
    total++; if (ram_ren !== 1'b1 || ram_addr !== 32'h2C0) begin bad++; $display("FAIL ovr_dbusy: got %b/%h want 1/2c0", ram_ren, ram_addr); end
    cyc(); cyc();
    ram_ready = 1'b1; ram_rdata = 32'h77; #1;
    total++; if (dwait !== 1'b0 || dload !== 32'h77) begin bad++; $display("FAIL ovr_d_done: got %b/%h want 0/77", dwait, dload); end
    total++; if (ovr_wait !== 1'b1) begin bad++; $display("FAIL ovr_d_ovrwait: got %b want 1", ovr_wait); end
    cyc();
    ram_ready = 1'b0; #1;
    total++; if (ram_ren !== 1'b0 || {iwait, dwait} !== 2'b11) begin bad++; $display("FAIL ovr_idle: got %b/%b want 0/11", ram_ren, {iwait, dwait}); end
    cyc();
    total++; if (ram_ren !== 1'b1 || ram_addr !== 32'h40) begin bad++; $display("FAIL ovr_grant: got %b/%h want 1/40", ram_ren, ram_addr); end
    total++; if ({iwait, dwait, ovr_wait} !== 3'b111) begin bad++; $display("FAIL ovr_pending: got %b want 111", {iwait, dwait, ovr_wait}); end
    cyc();
    ram_ready = 1'b1; ram_rdata = 32'hCAFE_0040; #1;
    total++; if (ovr_wait !== 1'b0 || ovr_rdata !== 32'hCAFE_0040) begin bad++; $display("FAIL ovr_done: got %b/%h want 0/cafe0040", ovr_wait, ovr_rdata); end
    total++; if ({iwait, dwait} !== 2'b11 || dload !== 32'h0) begin bad++; $display("FAIL ovr_cpu_held: got %b/%h want 11/0", {iwait, dwait}, dload); end
    ovr_ren = 1'b0;
    cyc();
    ram_ready = 1'b0;
    cyc();
    total++; if (ram_ren !== 1'b0 || dwait !== 1'b1) begin bad++; $display("FAIL ovr_lockout: got %b/%b want 0/1", ram_ren, dwait); end
    override_ctrl = 1'b0;
    cyc();
    total++; if (ram_ren !== 1'b1 || ram_addr !== 32'h2C0) begin bad++; $display("FAIL ovr_release: got %b/%h want 1/2c0", ram_ren, ram_addr); end
    dren = 1'b0; ram_ready = 1'b1;
    cyc();
    ram_ready = 1'b0;
    cyc();
  endtask

  task automatic test_drop();
    dren = 1'b1; daddr = 32'h3C0;
    cyc();
    dren = 1'b0;
    cyc();
    total++; if (ram_ren !== 1'b1 || ram_addr !== 32'h3C0) begin bad++; $display("FAIL drop_no_abort: got %b/%h want 1/3c0", ram_ren, ram_addr); end
    ram_ready = 1'b1; ram_rdata = 32'h99;
    cyc();
    ram_ready = 1'b0; #1;
    total++; if (ram_ren !== 1'b0) begin bad++; $display("FAIL drop_done: got %b want 0", ram_ren); end
    dwen = 1'b1; daddr = 32'h3C4; dstore = 32'hAB;
    cyc();
    total++; if ({ram_ren, ram_wen} !== 2'b01 || ram_addr !== 32'h3C4 || ram_wdata !== 32'hAB) begin bad++; $display("FAIL drop_next: got %b/%h/%h want 01/3c4/ab", {ram_ren, ram_wen}, ram_addr, ram_wdata); end
    ram_ready = 1'b1; #1;
    total++; if (dwait !== 1'b0) begin bad++; $display("FAIL drop_next_wait: got %b want 0", dwait); end
    cyc();
    dwen = 1'b0; ram_ready = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_dbusy();
    dren = 1'b1; daddr = 32'h300;
    cyc();
    total++; if (ram_ren !== 1'b1) begin bad++; $display("FAIL mrst_busy: got %b want 1", ram_ren); end
    nrst = 1'b0; #1;
    total++; if ({ram_ren, ram_wen} !== 2'b00) begin bad++; $display("FAIL mrst_strobes: got %b want 00", {ram_ren, ram_wen}); end
    // A ready now must not complete anything: the arbiter is back in IDLE
    ram_ready = 1'b1; ram_rdata = 32'h5A; #1;
    total++; if ({iwait, dwait, ovr_wait} !== 3'b111 || dload !== 32'h0) begin bad++; $display("FAIL mrst_waits: got %b/%h want 111/0", {iwait, dwait, ovr_wait}, dload); end
    dren = 1'b0; ram_ready = 1'b0;
    cyc();
    nrst = 1'b1;
    cyc();
    total++; if (ram_ren !== 1'b0 || ram_addr !== 32'h0) begin bad++; $display("FAIL mrst_after: got %b/%h want 0/0", ram_ren, ram_addr); end
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_priority();
    test_dstreak();
    test_override();
    test_drop();
    test_reset_mid_dbusy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
